// File: rtl/alu_cmd_sequencer.sv
// Command sequencer in front of the serial-operand ALU: takes one parallel
// command, feeds the ALU byte-serially, assembles and returns the result.
// Ports: clk/rst (sync, active-high); cmd_* valid/ready command input;
// res_* valid/ready result output; alu_* serial ALU interface.
module alu_cmd_sequencer #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_a,
  input  logic [7:0]  cmd_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        res_err,
  output logic [7:0]  alu_in,
  output logic [1:0]  alu_op,
  output logic        alu_begin,
  input  logic [7:0]  alu_out,
  input  logic        alu_end
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BEGIN,
    S_OPA,
    S_OPB,
    S_OPC,
    S_WAIT,
    S_CAP2,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  state_t           state;
  logic [15:0]      a_q;
  logic [7:0]       b_q;
  logic [7:0]       byte0;
  logic [CNT_W-1:0] cnt;
  logic             is_div;
  logic             div_bad;

  // alu_op holds the captured op for the whole transaction
  assign is_div = (alu_op == OP_DIV);

  // quotient would not fit in 8 bits
  assign div_bad = (cmd_op == OP_DIV) &&
                   ((cmd_b == 8'h00) || (cmd_a[15:8] >= cmd_b));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b1;
      res_valid <= 1'b0;
      res_err   <= 1'b0;
      res_data  <= 16'h0000;
      alu_begin <= 1'b0;
      alu_in    <= 8'h00;
      alu_op    <= 2'b00;
      cnt       <= '0;
      a_q       <= 16'h0000;
      b_q       <= 8'h00;
      byte0     <= 8'h00;
    end else begin
      alu_begin <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            a_q       <= cmd_a;
            b_q       <= cmd_b;
            cnt       <= '0;
            if (div_bad) begin
              state     <= S_DONE;
              res_valid <= 1'b1;
              res_err   <= 1'b1;
              res_data  <= 16'h0000;
            end else begin
              state     <= S_BEGIN;
              alu_begin <= 1'b1;
              alu_op    <= cmd_op;
            end
          end
        end
        S_BEGIN: begin
          alu_in <= is_div ? a_q[15:8] : a_q[7:0];
          state  <= S_OPA;
        end
        S_OPA: begin
          alu_in <= is_div ? a_q[7:0] : b_q;
          state  <= S_OPB;
        end
        S_OPB: begin
          if (is_div) begin
            alu_in <= b_q;
            state  <= S_OPC;
          end else begin
            state <= S_WAIT;
          end
        end
        S_OPC: state <= S_WAIT;
        S_WAIT: begin
          // end flag wins over a simultaneous timeout
          if (alu_end) begin
            byte0 <= alu_out;
            if (alu_op == OP_MUL || is_div) begin
              state <= S_CAP2;
            end else begin
              state     <= S_DONE;
              res_valid <= 1'b1;
              res_err   <= 1'b0;
              res_data  <= {8'h00, alu_out};
            end
          end else if (cnt == CNT_MAX) begin
            state     <= S_DONE;
            res_valid <= 1'b1;
            res_err   <= 1'b1;
            res_data  <= 16'h0000;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_CAP2: begin
          state     <= S_DONE;
          res_valid <= 1'b1;
          res_err   <= 1'b0;
          res_data  <= {byte0, alu_out};
        end
        S_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: behavioural ALU responder, command-level
// reference results in a scoreboard, decoupled result monitor.
module tb_alu_cmd_sequencer;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_a;
  logic [7:0]  cmd_b;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        res_err;
  logic [7:0]  alu_in;
  logic [1:0]  alu_op;
  logic        alu_begin;
  logic [7:0]  alu_out;
  logic        alu_end;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_err(res_err),
    .alu_in(alu_in), .alu_op(alu_op), .alu_begin(alu_begin),
    .alu_out(alu_out), .alu_end(alu_end)
  );

  typedef struct packed {
    logic [15:0] data;
    logic        err;
  } res_t;

  int   total = 0;
  int   bad = 0;
  res_t sb[$];
  bit   alu_mute = 1'b0;
  bit   hold_low = 1'b0;
  int   alu_delay = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic res_t expect_of(input logic [1:0] op,
                                     input logic [15:0] a,
                                     input logic [7:0] b);
    res_t e;
    int x, y, q, r;
    x = int'(a[7:0]);
    y = int'(b);
    e.err = 1'b0;
    e.data = 16'h0000;
    case (op)
      2'b00: e.data = {8'h00, 8'(x + y)};
      2'b01: e.data = {8'h00, 8'(x - y)};
      2'b10: e.data = 16'(x * y);
      default: begin
        x = int'(a);
        if (y == 0 || x / y > 255) begin
          e.err = 1'b1;
        end else begin
          q = x / y;
          r = x % y;
          e.data = {8'(q), 8'(r)};
        end
      end
    endcase
    return e;
  endfunction

  // behavioural ALU: reads operand bytes after the start pulse, answers later
  initial begin
    logic [1:0]  op;
    logic [7:0]  by [3];
    logic [15:0] r;
    int nb, n, dd, dv;
    alu_end = 1'b0;
    alu_out = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (alu_begin && !alu_mute && !rst) begin
        op = alu_op;
        nb = (op == 2'b11) ? 3 : 2;
        for (int i = 0; i < nb; i++) begin
          @(posedge clk); #1;
          by[i] = alu_in;
          check("alu_op_hold", 32'(alu_op), 32'(op));
          check("begin_pulse", 32'(alu_begin), 32'd0);
        end
        case (op)
          2'b00: r = {8'h00, by[0] + by[1]};
          2'b01: r = {8'h00, by[0] - by[1]};
          2'b10: r = 16'(int'(by[0]) * int'(by[1]));
          default: begin
            dd = int'({by[0], by[1]});
            dv = int'(by[2]);
            r = (dv == 0) ? 16'h0000 : {8'(dd / dv), 8'(dd % dv)};
          end
        endcase
        n = (alu_delay > 0) ? alu_delay : $urandom_range(1, 8);
        repeat (n) @(posedge clk);
        #1;
        alu_end = 1'b1;
        alu_out = (op < 2'b10) ? r[7:0] : r[15:8];
        @(posedge clk); #1;
        alu_end = 1'b0;
        alu_out = (op < 2'b10) ? 8'($urandom) : r[7:0];
      end
    end
  end

  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      res_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // result monitor
  initial begin
    res_t        e;
    bit          stall_prev;
    logic [15:0] held_d;
    logic        held_e;
    stall_prev = 1'b0;
    held_d = 16'h0;
    held_e = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev && res_valid) begin
          check("hold_data", 32'(res_data), 32'(held_d));
          check("hold_err", 32'(res_err), 32'(held_e));
        end
        if (res_valid) check("ready_in_done", 32'(cmd_ready), 32'd0);
        if (res_valid && res_ready) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result got=%h want=none", res_data);
          end else begin
            e = sb.pop_front();
            check("res_data", 32'(res_data), 32'(e.data));
            check("res_err", 32'(res_err), 32'(e.err));
          end
        end
        stall_prev = res_valid && !res_ready;
        held_d = res_data;
        held_e = res_err;
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [15:0] a,
                       input logic [7:0] b, input bit push,
                       input bit force_err);
    int   t;
    res_t e;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_a = a;
    cmd_b = b;
    t = 0;
    while (!cmd_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout got=0 want=1");
    end else if (push) begin
      e = expect_of(op, a, b);
      if (force_err) e = '{data: 16'h0000, err: 1'b1};
      sb.push_back(e);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || res_valid) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      total++;
      bad++;
      $display("FAIL drain_timeout got=%0d want=0", sb.size());
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_res_err"}, 32'(res_err), 32'd0);
    check({tag, "_res_data"}, 32'(res_data), 32'd0);
    check({tag, "_alu_begin"}, 32'(alu_begin), 32'd0);
    check({tag, "_alu_in"}, 32'(alu_in), 32'd0);
    check({tag, "_alu_op"}, 32'(alu_op), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  op;
    logic [15:0] a;
    logic [7:0]  b;
    int t;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cmd_a = 16'h0;
    cmd_b = 8'h0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    issue(2'b00, 16'h0002, 8'h03, 1, 0);
    issue(2'b01, 16'h0002, 8'h07, 1, 0);
    issue(2'b10, 16'h00C5, 8'h04, 1, 0);
    issue(2'b11, 16'h3112, 8'h7B, 1, 0);
    issue(2'b11, 16'h1000, 8'h10, 1, 0);
    issue(2'b11, 16'h1234, 8'h00, 1, 0);
    issue(2'b11, 16'h0FFF, 8'h10, 1, 0);
    issue(2'b10, 16'hAAFF, 8'hFF, 1, 0);
    drain();

    // end flag on the last allowed wait cycle, then one cycle too late
    alu_delay = TIMEOUT + 1;
    issue(2'b10, 16'h0011, 8'h22, 1, 0);
    drain();
    alu_delay = TIMEOUT + 2;
    issue(2'b00, 16'h0011, 8'h22, 1, 1);
    drain();
    alu_delay = 0;
    repeat (4) @(negedge clk);

    alu_mute = 1'b1;
    issue(2'b11, 16'h0280, 8'h40, 1, 1);
    drain();
    alu_mute = 1'b0;

    // consumer stall
    hold_low = 1'b1;
    issue(2'b10, 16'h0033, 8'h05, 1, 0);
    t = 0;
    while (!res_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("stall_reached", 32'(res_valid), 32'd1);
    repeat (5) begin
      @(negedge clk);
      check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
      check("stall_valid", 32'(res_valid), 32'd1);
    end
    hold_low = 1'b0;
    drain();

    // reset during the second operand cycle
    alu_mute = 1'b1;
    issue(2'b01, 16'h0055, 8'hA6, 0, 0);
    @(negedge clk);
    @(negedge clk);
    check("opb_byte", 32'(alu_in), 32'hA6);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("abort");
    rst = 1'b0;
    repeat (12) @(negedge clk);
    alu_mute = 1'b0;
    check("post_abort_idle", 32'(res_valid), 32'd0);

    for (int i = 0; i < 150; i++) begin
      op = 2'($urandom);
      a = 16'($urandom);
      b = 8'($urandom);
      if (op == 2'b11 && $urandom_range(0, 3) != 0) begin
        if (b == 8'h00) b = 8'h01;
        a[15:8] = 8'($urandom_range(0, int'(b) - 1));
      end
      issue(op, a, b, 1, 0);
    end
    drain();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
